// File: rtl/ddfs_div_pkg.sv
// Shared types and constants for the programmable DDFS clock divider.
// Decade divisor table, minimum divisor, and the custom-select code.
package ddfs_div_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } div_state_e;

  localparam int unsigned DIV_MIN    = 2;
  localparam int unsigned SEL_CUSTOM = 7;

  localparam int unsigned DIV_DEC [0:6] = '{
    2, 10, 100, 1000, 10000, 100000, 1000000
  };

  // Code 0 maps to 2 rather than 1 so the table never yields a divide-by-1.
  function automatic int unsigned dec_div(input int unsigned sel);
    case (sel)
      0:       return DIV_DEC[0];
      1:       return DIV_DEC[1];
      2:       return DIV_DEC[2];
      3:       return DIV_DEC[3];
      4:       return DIV_DEC[4];
      5:       return DIV_DEC[5];
      6:       return DIV_DEC[6];
      default: return DIV_MIN;
    endcase
  endfunction

endpackage

// File: rtl/div_sel_decode.sv
// Combinational divisor select: decade table or clamped custom value.
// Result is only sampled by the top at period load points.
module div_sel_decode
  import ddfs_div_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] freq_cntrl,
  input  logic [CNT_W-1:0] div_custom,
  output logic [CNT_W-1:0] req_div
);

  always_comb begin
    req_div = CNT_W'(DIV_MIN);
    if (int'(unsigned'(freq_cntrl)) == int'(SEL_CUSTOM)) begin
      // Divide-by-0/1 would collapse the period; hold the floor at 2.
      if (div_custom < CNT_W'(DIV_MIN))
        req_div = CNT_W'(DIV_MIN);
      else
        req_div = div_custom;
    end else begin
      req_div = CNT_W'(dec_div(int'(unsigned'(freq_cntrl))));
    end
  end

endmodule

// File: rtl/prog_freq_divider.sv
// Glitch-free programmable clock divider: clk_out, tick strobe, run status.
// Divisor and stop requests are only honoured at period boundaries.
module prog_freq_divider
  import ddfs_div_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int SEL_W = 3
) (
  input  logic             clk_in,
  input  logic             arstn,
  input  logic             en,
  input  logic [SEL_W-1:0] freq_cntrl,
  input  logic [CNT_W-1:0] div_custom,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] div_active
);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hi_time;
  logic [CNT_W-1:0] req_div;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;

  div_sel_decode #(
    .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) u_dec (
    .freq_cntrl (freq_cntrl),
    .div_custom (div_custom),
    .req_div    (req_div)
  );

  assign cnt_nxt = count + CNT_W'(1);
  assign wrap    = (count == div_active - CNT_W'(1));

  always_ff @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      state      <= STOP;
      count      <= '0;
      div_active <= CNT_W'(DIV_MIN);
      hi_time    <= CNT_W'(DIV_MIN >> 1);
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        STOP: begin
          count   <= '0;
          clk_out <= 1'b0;
          if (en) begin
            state      <= RUN;
            div_active <= req_div;
            hi_time    <= req_div >> 1;
            clk_out    <= 1'b1;
            tick       <= 1'b1;
            running    <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (wrap) begin
            count <= '0;
            if (en) begin
              state      <= RUN;
              div_active <= req_div;
              hi_time    <= req_div >> 1;
              clk_out    <= 1'b1;
              tick       <= 1'b1;
            end else begin
              // Period is complete; the old divisor stays visible while stopped.
              state   <= STOP;
              clk_out <= 1'b0;
              running <= 1'b0;
            end
          end else begin
            count   <= cnt_nxt;
            clk_out <= (cnt_nxt < hi_time);
            state   <= en ? RUN : DRAIN;
          end
        end
        default: begin
          state   <= STOP;
          count   <= '0;
          clk_out <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider: period-level model checked every cycle
// plus hand-computed spot checks on latency, spacing and duty.
module tb_prog_freq_divider;

  logic        clk_in = 1'b0;
  logic        arstn;
  logic        en;
  logic [2:0]  freq_cntrl;
  logic [19:0] div_custom;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic [19:0] div_active;

  int nvec = 0;
  int nerr = 0;

  prog_freq_divider #(.CNT_W(20), .SEL_W(3)) dut (
    .clk_in     (clk_in),
    .arstn      (arstn),
    .en         (en),
    .freq_cntrl (freq_cntrl),
    .div_custom (div_custom),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running),
    .div_active (div_active)
  );

  always #5 clk_in = ~clk_in;

  // Model: a running flag, position within the current period, and its length.
  bit m_run;
  int m_pos;
  int m_n;

  function automatic int model_req();
    int v;
    if (freq_cntrl == 3'd7) return (div_custom < 20'd2) ? 2 : int'(div_custom);
    if (freq_cntrl == 3'd0) return 2;
    v = 1;
    for (int i = 0; i < int'(freq_cntrl); i++) v = v * 10;
    return v;
  endfunction

  always @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      m_run = 0; m_pos = 0; m_n = 2;
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; m_n = model_req(); end
    end else if (m_pos == m_n - 1) begin
      m_pos = 0;
      if (en) m_n = model_req();
      else    m_run = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    check("model_clk_out", 32'(clk_out), 32'(m_run && (m_pos < m_n / 2)));
    check("model_tick",    32'(tick),    32'(m_run && m_pos == 0));
    check("model_running", 32'(running), 32'(m_run));
    check("model_div",     32'(div_active), 32'(m_n));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      step(1);
      cycles++;
      if (tick === 1'b1) return;
    end
    nvec++; nerr++;
    $display("FAIL wait_tick: no tick within %0d cycles", budget);
  endtask

  int cyc, hi, nt;

  initial begin
    arstn = 1'b0; en = 1'b0; freq_cntrl = 3'd1; div_custom = 20'd0;
    step(2);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick",    32'(tick), 0);
    check("rst_running", 32'(running), 0);
    check("rst_div",     32'(div_active), 2);
    arstn = 1'b1;
    step(1);
    en = 1'b1;
    step(1);
    check("start_tick", 32'(tick), 1);
    check("start_clk",  32'(clk_out), 1);
    check("start_div",  32'(div_active), 10);
    hi = 0; nt = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(clk_out); nt += int'(tick); step(1);
    end
    check("dec1_high", 32'(hi), 5);
    check("dec1_ticks", 32'(nt), 1);

    // Mid-period change 100 -> 2
    freq_cntrl = 3'd2;
    wait_tick(20, cyc);
    check("to100_spacing", 32'(cyc), 10);
    check("to100_div", 32'(div_active), 100);
    step(37);
    freq_cntrl = 3'd0;
    wait_tick(200, cyc);
    check("mid_change_rest", 32'(cyc), 63);
    check("mid_change_div", 32'(div_active), 2);
    wait_tick(10, cyc);
    check("div2_spacing", 32'(cyc), 2);

    // Odd custom divisor and clamps
    freq_cntrl = 3'd7; div_custom = 20'd5;
    wait_tick(10, cyc);
    check("cust5_div", 32'(div_active), 5);
    hi = 0;
    for (int i = 0; i < 5; i++) begin hi += int'(clk_out); step(1); end
    check("cust5_high", 32'(hi), 2);
    check("cust5_tick", 32'(tick), 1);
    div_custom = 20'd0;
    wait_tick(10, cyc);
    check("cust0_div", 32'(div_active), 2);
    div_custom = 20'd1;
    wait_tick(10, cyc);
    check("cust1_spacing", 32'(cyc), 2);
    check("cust1_div", 32'(div_active), 2);

    // Stop via drain
    freq_cntrl = 3'd1;
    wait_tick(10, cyc);
    check("stop_div", 32'(div_active), 10);
    step(3);
    en = 1'b0;
    step(6);
    check("drain_running", 32'(running), 1);
    check("drain_clk", 32'(clk_out), 0);
    step(1);
    check("stopped_running", 32'(running), 0);
    check("stopped_clk", 32'(clk_out), 0);
    step(5);
    check("idle_div", 32'(div_active), 10);

    // Drain cancelled
    en = 1'b1;
    step(1);
    check("restart_tick", 32'(tick), 1);
    step(3);
    en = 1'b0;
    step(4);
    en = 1'b1;
    wait_tick(20, cyc);
    check("drain_cancel_rest", 32'(cyc), 3);
    check("drain_cancel_run", 32'(running), 1);

    // Async reset mid-period
    freq_cntrl = 3'd3;
    wait_tick(20, cyc);
    check("to1000_div", 32'(div_active), 1000);
    step(400);
    #2 arstn = 1'b0;
    #1;
    check("arst_clk", 32'(clk_out), 0);
    check("arst_running", 32'(running), 0);
    check("arst_div", 32'(div_active), 2);
    step(2);
    arstn = 1'b1;
    step(1);
    check("post_rst_tick", 32'(tick), 1);
    check("post_rst_div", 32'(div_active), 1000);

    // Maximum divisor (partial observation of the high phase)
    freq_cntrl = 3'd6;
    wait_tick(1100, cyc);
    check("max_div", 32'(div_active), 1000000);
    hi = 0; nt = 0;
    for (int i = 0; i < 3000; i++) begin
      hi += int'(clk_out); nt += int'(tick); step(1);
    end
    check("max_high", 32'(hi), 3000);
    check("max_ticks", 32'(nt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/prog_freq_divider.md
# prog_freq_divider

Parametrised, glitch-free successor to the fixed decade clock divider in the DDFS module. It divides `clk_in` by a decade divisor (2, 10 … 10^6) or a run-time custom divisor and produces a near-50 % duty `clk_out` plus a one-cycle `tick` strobe. Divisor changes and stop requests take effect only at period boundaries, so no runt or truncated periods reach the DDFS sample-rate logic.

## Interface
- `CNT_W`, 20: counter and divisor width; must hold `10^6 - 1`.
- `SEL_W`, 3: width of `freq_cntrl`.
- `clk_in`  in  1  system clock.
- `arstn`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; sampled every `clk_in` edge.
- `freq_cntrl`  in  SEL_W  selects the divisor:
  - 0 → 2, 1 → 10, 2 → 100, 3 → 1000, 4 → 10^4, 5 → 10^5, 6 → 10^6.
  - 7 → `div_custom`.
- `div_custom`  in  CNT_W  custom divisor N. Values below 2 are clamped to 2.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse, coincident with each rising edge of `clk_out`.
- `running`  out  1  high in RUN or DRAIN.
- `div_active`  out  CNT_W  divisor currently in effect.

## Operation
- **Requested divisor:** `req_div` = decoded `freq_cntrl` (or clamped `div_custom`). It is combinational and is sampled only at a load point.
- **Load points:**
  - the STOP→RUN transition;
  - every wrap (`count == div_active - 1`) in RUN.
- **High time:** H = `div_active >> 1`, recomputed from the new divisor at each load.
- **State machine:**
  - STOP:
    - `count` = 0, `clk_out` = 0.
    - `en` = 1 → RUN. On that edge: load `req_div`, `count` <= 0, `clk_out` <= 1, `tick` <= 1.
  - RUN:
    - Not at wrap: `count` <= `count + 1`, `clk_out` <= (`count + 1` < H).
    - At wrap with `en` = 1: `count` <= 0, load `req_div`, `clk_out` <= 1, `tick` <= 1.
    - At wrap with `en` = 0: go to STOP, `clk_out` <= 0, `count` <= 0, divisor not reloaded.
    - `en` = 0 before wrap → DRAIN.
  - DRAIN:
    - Keeps counting exactly as RUN.
    - `en` = 1 → back to RUN with no disturbance to `count` or `clk_out`.
    - At wrap → STOP, as above.
- **Duty cycle:**
  - Even N: exactly 50 %.
  - Odd N: high for ⌊N/2⌋ cycles, low for ⌈N/2⌉ cycles.
- **Arithmetic:** all compares are unsigned at CNT_W bits; no wrap-around of `count` past `div_active - 1`.
- **Divisor changes:** a change of `freq_cntrl` or `div_custom` mid-period is ignored until the next load point. The only exception is that STOP samples on its exit edge.

## Timing
- **Reset (async assert):**
  - `clk_out` = 0, `tick` = 0, `running` = 0, `count` = 0.
  - `div_active` = 2, state STOP.
  - Deassertion is used synchronously.
- **Start latency:** `en` sampled high at edge k → `clk_out` = 1, `tick` = 1, `running` = 1 after edge k.
- **Period:** exactly `div_active` cycles from `tick` to `tick`.
- **`div_active`:** updates on the same edge as the `tick` it governs.
- **Stop:** `running` falls on the edge that completes the current period; `clk_out` is already 0 at that point.
- **Reset mid-period:** immediate return to reset values; no completion of the period.
- **Simultaneous divisor change and wrap:** the new value is used for the period that starts on that edge.

## Structure
- **Package `ddfs_div_pkg`:**
  - state enum {STOP, RUN, DRAIN};
  - decade divisor constants `DIV_DEC[0:6]`;
  - `DIV_MIN` = 2;
  - `SEL_CUSTOM` = 7.
- **Sub-module `div_sel_decode`:** combinational `freq_cntrl`/`div_custom` → `req_div`, including the clamp.
- **Top:** FSM, counter, and output registers.

## Test plan
- **Reset and decade 1:** reset, then `en` = 1 with `freq_cntrl` = 1 → `tick` every 10 cycles; `clk_out` high 5 cycles, low 5; `div_active` = 10.
- **Mid-period change:** `freq_cntrl` switched 2 → 0 at count 37 → remaining 63 cycles of the 100-cycle period complete, then `clk_out` toggles every cycle; no period shorter than 2.
- **Odd custom divisor:** `freq_cntrl` = 7, `div_custom` = 5 → high 2, low 3. `div_custom` = 0 or 1 → behaves as N = 2.
- **Stop and drain:** `en` dropped at count 3 of N = 10 → 6 more cycles, `running` falls at wrap, `clk_out` stays 0. `en` re-asserted at count 7 instead → uninterrupted periods.
- **Async reset mid-period:** `arstn` low at count 400 of N = 1000 → all outputs 0 immediately. After release with `en` = 1, the first `tick` comes on the first edge.
- **Maximum divisor:** `freq_cntrl` = 6 → `tick` spacing 1 000 000 cycles; `clk_out` high 500 000 cycles.
